// File: rtl/la_trig_pkg.sv
// Shared definitions for the multi-stage logic-analyzer trigger engine.
package la_trig_pkg;

  // Upper bound on the number of sequential stages (stage_idx is 3 bits).
  localparam int MAX_STAGES = 8;

  // Per-stage combine mode for the level and change-detect terms.
  localparam logic COMB_AND = 1'b0;
  localparam logic COMB_OR  = 1'b1;

  // One-hot sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_PRIME = 4'b0010,
    ST_ARMED = 4'b0100,
    ST_TRIG  = 4'b1000
  } state_e;

endpackage

// File: rtl/la_stage_match.sv
// Combinational match for one trigger stage: level compare plus
// change detect, combined by AND or OR. A zero mask makes its term
// "don't care".
module la_stage_match
  import la_trig_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_sync,
  input  logic [WIDTH-1:0] data_prev,
  input  logic [WIDTH-1:0] lvl_mask,
  input  logic [WIDTH-1:0] lvl_val,
  input  logic [WIDTH-1:0] diff_mask,
  input  logic             comb_mode,
  input  logic             prev_valid,
  output logic             match
);

  logic lvl_dc;
  logic diff_dc;
  logic lvl_hit;
  logic diff_hit;
  logic and_match;
  logic or_match;

  // Evaluate both terms and pick the combination selected for this stage.
  always_comb begin
    lvl_dc    = (lvl_mask == '0);
    diff_dc   = (diff_mask == '0);
    lvl_hit   = (((data_sync ^ lvl_val) & lvl_mask) == '0);
    // Until the previous sample is meaningful, a change can never hit.
    diff_hit  = prev_valid && (((data_sync ^ data_prev) & diff_mask) != '0);
    and_match = (lvl_dc || lvl_hit) && (diff_dc || diff_hit);
    // OR mode only considers terms that are actually enabled.
    or_match  = (lvl_dc && diff_dc) || (!lvl_dc && lvl_hit) || (!diff_dc && diff_hit);
    case (comb_mode)
      COMB_AND: match = and_match;
      COMB_OR:  match = or_match;
      default:  match = and_match;
    endcase
  end

endmodule

// File: rtl/la_trig_seq.sv
// Multi-stage LA trigger sequencer. Samples the LA bus into a two-deep
// pipeline, matches the current stage's condition, counts consecutive
// hits and steps through the stages until the final one fires the trigger.
module la_trig_seq
  import la_trig_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          DATA_IN,
  input  logic [STAGES*WIDTH-1:0]   LVL_MASK,
  input  logic [STAGES*WIDTH-1:0]   LVL_VAL,
  input  logic [STAGES*WIDTH-1:0]   DIFF_MASK,
  input  logic [STAGES-1:0]         COMB_MODE,
  input  logic [STAGES*CNT_W-1:0]   HIT_CNT,
  output logic                      trig_out,
  output logic                      trig_pulse,
  output logic [2:0]                stage_idx,
  output logic                      armed
);

  localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

  state_e           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [WIDTH-1:0] data_sync_q, data_sync_d;
  logic [WIDTH-1:0] data_prev_q, data_prev_d;

  // Config slices unpacked per stage; unused stage slots read as zero.
  logic [WIDTH-1:0] lvl_mask_a  [MAX_STAGES];
  logic [WIDTH-1:0] lvl_val_a   [MAX_STAGES];
  logic [WIDTH-1:0] diff_mask_a [MAX_STAGES];
  logic             comb_mode_a [MAX_STAGES];
  logic [CNT_W-1:0] hit_cnt_a   [MAX_STAGES];

  for (genvar k = 0; k < MAX_STAGES; k++) begin : g_cfg
    if (k < STAGES) begin : g_used
      assign lvl_mask_a[k]  = LVL_MASK[k*WIDTH +: WIDTH];
      assign lvl_val_a[k]   = LVL_VAL[k*WIDTH +: WIDTH];
      assign diff_mask_a[k] = DIFF_MASK[k*WIDTH +: WIDTH];
      assign comb_mode_a[k] = COMB_MODE[k];
      assign hit_cnt_a[k]   = HIT_CNT[k*CNT_W +: CNT_W];
    end else begin : g_unused
      assign lvl_mask_a[k]  = '0;
      assign lvl_val_a[k]   = '0;
      assign diff_mask_a[k] = '0;
      assign comb_mode_a[k] = COMB_AND;
      assign hit_cnt_a[k]   = '0;
    end
  end

  logic match;
  logic prev_valid;

  // The PRIME cycle is the only one where the previous sample may be stale.
  assign prev_valid = (state_q == ST_ARMED);

  la_stage_match #(
    .WIDTH (WIDTH)
  ) u_match (
    .data_sync  (data_sync_q),
    .data_prev  (data_prev_q),
    .lvl_mask   (lvl_mask_a[stage_q]),
    .lvl_val    (lvl_val_a[stage_q]),
    .diff_mask  (diff_mask_a[stage_q]),
    .comb_mode  (comb_mode_a[stage_q]),
    .prev_valid (prev_valid),
    .match      (match)
  );

  // Hit counting: a programmed count of 0 behaves as 1.
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   cnt_need;
  logic [CNT_W-1:0] cnt_sat;
  logic             stage_done;

  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_need   = (hit_cnt_a[stage_q] == '0) ? (CNT_W+1)'(1) : {1'b0, hit_cnt_a[stage_q]};
  assign cnt_sat    = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
  assign stage_done = match && (cnt_inc >= cnt_need);

  // Next-state, stage and counter logic for the trigger sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    pulse_d     = 1'b0;
    data_sync_d = DATA_IN;
    data_prev_d = data_sync_q;

    if (!EN) begin
      state_d = ST_IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          state_d = ST_ARMED;
          stage_d = '0;
          cnt_d   = '0;
        end
        ST_ARMED: begin
          if (!match) begin
            // A break in the run restarts this stage's count only.
            cnt_d = '0;
          end else if (stage_done) begin
            cnt_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = ST_TRIG;
              pulse_d = 1'b1;
            end else begin
              stage_d = stage_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_sat;
          end
        end
        ST_TRIG: begin
          state_d = ST_TRIG;
        end
        default: begin
          state_d = ST_IDLE;
          stage_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and sample pipeline registers.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and sampled on the clock edge; it overrides EN.
    if (RST) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      data_sync_q <= '0;
      data_prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      data_sync_q <= data_sync_d;
      data_prev_q <= data_prev_d;
    end
  end

  assign trig_out   = (state_q == ST_TRIG);
  assign trig_pulse = pulse_q;
  assign stage_idx  = stage_q;
  assign armed      = (state_q == ST_ARMED);

endmodule

// File: tb/tb_la_trig_seq.sv
// Self-checking bench for la_trig_seq: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_la_trig_seq;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    EN;
  logic [WIDTH-1:0]        DATA_IN;
  logic [STAGES*WIDTH-1:0] LVL_MASK;
  logic [STAGES*WIDTH-1:0] LVL_VAL;
  logic [STAGES*WIDTH-1:0] DIFF_MASK;
  logic [STAGES-1:0]       COMB_MODE;
  logic [STAGES*CNT_W-1:0] HIT_CNT;
  logic                    trig_out;
  logic                    trig_pulse;
  logic [2:0]              stage_idx;
  logic                    armed;

  la_trig_seq #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .DATA_IN    (DATA_IN),
    .LVL_MASK   (LVL_MASK),
    .LVL_VAL    (LVL_VAL),
    .DIFF_MASK  (DIFF_MASK),
    .COMB_MODE  (COMB_MODE),
    .HIT_CNT    (HIT_CNT),
    .trig_out   (trig_out),
    .trig_pulse (trig_pulse),
    .stage_idx  (stage_idx),
    .armed      (armed)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 priming, 2 hunting, 3 fired.
  int         m_phase = 0;
  int         m_stage = 0;
  int         m_run   = 0;
  bit         m_pulse = 0;
  logic [7:0] m_sync  = '0;
  logic [7:0] m_prev  = '0;

  function automatic bit model_match(int k);
    bit lvl_care  = 0;
    bit lvl_ok    = 1;
    bit diff_care = 0;
    bit diff_ok   = 0;
    for (int b = 0; b < WIDTH; b++) begin
      if (LVL_MASK[k*WIDTH+b]) begin
        lvl_care = 1;
        if (m_sync[b] != LVL_VAL[k*WIDTH+b]) lvl_ok = 0;
      end
      if (DIFF_MASK[k*WIDTH+b]) begin
        diff_care = 1;
        if (m_sync[b] != m_prev[b]) diff_ok = 1;
      end
    end
    if (!lvl_care && !diff_care) return 1'b1;
    if (COMB_MODE[k]) return (lvl_care && lvl_ok) || (diff_care && diff_ok);
    return (!lvl_care || lvl_ok) && (!diff_care || diff_ok);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0; m_stage = 0; m_run = 0; m_pulse = 0;
      m_sync = '0; m_prev = '0;
    end else begin
      m_pulse = 0;
      if (!EN) begin
        m_phase = 0; m_stage = 0; m_run = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2; m_stage = 0; m_run = 0;
      end else if (m_phase == 2) begin
        if (model_match(m_stage)) begin
          int need;
          need = int'(HIT_CNT[m_stage*CNT_W +: CNT_W]);
          if (need == 0) need = 1;
          if (m_run + 1 >= need) begin
            m_run = 0;
            if (m_stage == STAGES - 1) begin
              m_phase = 3; m_pulse = 1;
            end else begin
              m_stage = m_stage + 1;
            end
          end else begin
            m_run = (m_run + 1 > 255) ? 255 : m_run + 1;
          end
        end else begin
          m_run = 0;
        end
      end
      m_prev = m_sync;
      m_sync = DATA_IN;
    end
  end

  // Continuous comparison of every output against the model.
  bit mon_en = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      check("mon_trig",  32'(trig_out),   32'(m_phase == 3));
      check("mon_pulse", 32'(trig_pulse), 32'(m_pulse));
      check("mon_stage", 32'(stage_idx),  32'(m_stage));
      check("mon_armed", 32'(armed),      32'(m_phase == 2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [7:0] d);
    DATA_IN = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_stage(input int k, input logic [7:0] lm, input logic [7:0] lv,
                           input logic [7:0] dm, input logic mode, input logic [7:0] hc);
    LVL_MASK[k*WIDTH +: WIDTH]  = lm;
    LVL_VAL[k*WIDTH +: WIDTH]   = lv;
    DIFF_MASK[k*WIDTH +: WIDTH] = dm;
    COMB_MODE[k]                = mode;
    HIT_CNT[k*CNT_W +: CNT_W]   = hc;
  endtask

  // Disarm for a cycle, then arm with a steady sample so the sequencer is hunting.
  task automatic arm(input logic [7:0] d);
    EN = 1'b0;
    tick(d);
    EN = 1'b1;
    tick(d);
    tick(d);
  endtask

  function automatic logic [7:0] sparse_mask();
    logic [7:0] m;
    m = '0;
    if ($urandom_range(0, 2) != 0) m[$urandom_range(0, 7)] = 1'b1;
    if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 7)] = 1'b1;
    return m;
  endfunction

  initial begin
    RST = 1'b1; EN = 1'b0; DATA_IN = '0;
    LVL_MASK = '0; LVL_VAL = '0; DIFF_MASK = '0; COMB_MODE = '0; HIT_CNT = '0;
    @(negedge CLK);
    tick(8'h00);
    tick(8'h00);
    check("rst_trig",  32'(trig_out),   32'd0);
    check("rst_pulse", 32'(trig_pulse), 32'd0);
    check("rst_stage", 32'(stage_idx),  32'd0);
    check("rst_armed", 32'(armed),      32'd0);
    RST = 1'b0;
    mon_en = 1;

    // Level trigger across two stages.
    set_stage(0, 8'hFF, 8'hA5, 8'h00, 1'b0, 8'd1);
    set_stage(1, 8'h01, 8'h01, 8'h00, 1'b0, 8'd1);
    arm(8'h00);
    check("lvl_armed", 32'(armed), 32'd1);
    tick(8'hA5);
    tick(8'h81);
    check("lvl_stage1", 32'(stage_idx), 32'd1);
    check("lvl_no_trig_yet", 32'(trig_out), 32'd0);
    tick(8'h00);
    check("lvl_trig", 32'(trig_out), 32'd1);
    check("lvl_pulse", 32'(trig_pulse), 32'd1);
    tick(8'h00);
    check("lvl_pulse_once", 32'(trig_pulse), 32'd0);
    check("lvl_trig_hold", 32'(trig_out), 32'd1);

    // Disarm clears everything; re-arming passes through one priming cycle.
    EN = 1'b0;
    tick(8'h00);
    check("dis_trig",  32'(trig_out),  32'd0);
    check("dis_armed", 32'(armed),     32'd0);
    check("dis_stage", 32'(stage_idx), 32'd0);
    EN = 1'b1;
    tick(8'h00);
    check("rearm_prime", 32'(armed), 32'd0);
    tick(8'h00);
    check("rearm_armed", 32'(armed), 32'd1);

    // Edge on bit 7 arriving with arming must be ignored while priming.
    set_stage(0, 8'h00, 8'h00, 8'h80, 1'b0, 8'd1);
    set_stage(1, 8'hFF, 8'h5A, 8'h00, 1'b0, 8'd1);
    EN = 1'b0;
    tick(8'h00);
    tick(8'h00);
    EN = 1'b1;
    tick(8'h80);
    tick(8'h80);
    tick(8'h80);
    check("edge_prime_hold", 32'(stage_idx), 32'd0);
    tick(8'h00);
    tick(8'h00);
    check("edge_fall_adv", 32'(stage_idx), 32'd1);

    // Consecutive count of three with a gap restarting the run.
    set_stage(0, 8'h0F, 8'h03, 8'h00, 1'b0, 8'd3);
    set_stage(1, 8'h00, 8'h00, 8'h00, 1'b0, 8'd1);
    arm(8'h00);
    tick(8'h03);
    tick(8'h03);
    tick(8'h00);
    tick(8'h03);
    tick(8'h03);
    tick(8'h03);
    check("cnt_not_yet", 32'(stage_idx), 32'd0);
    tick(8'h00);
    check("cnt_adv", 32'(stage_idx), 32'd1);

    // OR mode: change alone, then level alone.
    set_stage(0, 8'h01, 8'h01, 8'h02, 1'b1, 8'd1);
    set_stage(1, 8'hFF, 8'h5A, 8'h00, 1'b0, 8'd1);
    arm(8'h00);
    tick(8'h02);
    check("or_diff_wait", 32'(stage_idx), 32'd0);
    tick(8'h02);
    check("or_diff_adv", 32'(stage_idx), 32'd1);
    arm(8'h00);
    tick(8'h01);
    check("or_lvl_wait", 32'(stage_idx), 32'd0);
    tick(8'h01);
    check("or_lvl_adv", 32'(stage_idx), 32'd1);

    // Reset mid-sequence with EN held high.
    set_stage(0, 8'h00, 8'h00, 8'h00, 1'b0, 8'd1);
    set_stage(1, 8'hFF, 8'h3C, 8'h00, 1'b0, 8'd4);
    arm(8'h3C);
    tick(8'h3C);
    tick(8'h3C);
    tick(8'h3C);
    check("rp_stage1", 32'(stage_idx), 32'd1);
    RST = 1'b1;
    tick(8'h3C);
    RST = 1'b0;
    check("rp_trig",  32'(trig_out),   32'd0);
    check("rp_pulse", 32'(trig_pulse), 32'd0);
    check("rp_stage", 32'(stage_idx),  32'd0);
    check("rp_armed", 32'(armed),      32'd0);
    tick(8'h3C);
    check("rp_prime", 32'(armed), 32'd0);
    tick(8'h3C);
    check("rp_armed0", 32'(armed), 32'd1);
    check("rp_stage0", 32'(stage_idx), 32'd0);

    // Randomized traffic with fresh configuration per epoch.
    for (int ep = 0; ep < 30; ep++) begin
      EN = 1'b0;
      for (int k = 0; k < STAGES; k++)
        set_stage(k, sparse_mask(), 8'($urandom), sparse_mask(), 1'($urandom),
                  8'($urandom_range(0, 3)));
      tick(8'($urandom));
      EN = 1'b1;
      for (int c = 0; c < 40; c++) begin
        logic [7:0] d;
        case ($urandom_range(0, 3))
          0: d = LVL_VAL[7:0];
          1: d = LVL_VAL[15:8];
          2: d = DATA_IN;
          default: d = 8'($urandom);
        endcase
        if ($urandom_range(0, 29) == 0) EN = 1'b0;
        else EN = 1'b1;
        RST = ($urandom_range(0, 49) == 0);
        tick(d);
      end
      RST = 1'b0;
    end

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
